// File: rtl/io_bridge_pkg.sv
// Shared constants for the CPU I/O bridge: register address, command and status bit positions.
package io_bridge_pkg;

  localparam logic [31:0] IO_ADDR = 32'h7FFF_FFFC;

  localparam int CMD_PUSH = 8;
  localparam int CMD_POP  = 9;
  localparam int CMD_CLR  = 10;

  localparam int ST_RXNE   = 8;
  localparam int ST_TXF    = 9;
  localparam int ST_TXE    = 10;
  localparam int ST_TXDROP = 11;
  localparam int ST_RXUF   = 12;

  localparam int ST_TXCNT_LSB = 16;
  localparam int ST_RXCNT_LSB = 24;
  localparam int ST_CNT_W     = 5;

endpackage

// File: rtl/io_bridge_if.sv
// CPU I/O word port plus the two external byte-stream handshakes of the bridge.
interface io_bridge_if;
  logic [31:0] CPUOut;
  logic        IOWrite;
  logic [31:0] CPUIn;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;

  modport slave (
    input  CPUOut, IOWrite, tx_ready, rx_valid, rx_data,
    output CPUIn, tx_valid, tx_data, rx_ready
  );

  modport master (
    output CPUOut, IOWrite, tx_ready, rx_valid, rx_data,
    input  CPUIn, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/io_bridge_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only alongside a pop.
// Pushes/pops on an empty or full FIFO are ignored internally; dout reads 0 while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign count  = r_count;
  assign dout   = empty ? '0 : r_mem[r_rd];

  // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr] <= din;
  end
endmodule

// File: rtl/io_bridge.sv
// CPU-side I/O bridge: decodes command writes into TX/RX FIFO operations and assembles the status word.
// CPUIn is built purely from registered state, so no path exists from IOWrite/CPUOut to CPUIn.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = 5
) (
  input  logic        CLK,
  input  logic        Reset,
  io_bridge_if.slave  bus
);
  logic          w_cmd_push;
  logic          w_cmd_pop;
  logic          w_cmd_clr;
  logic [7:0]    w_tx_dout;
  logic [7:0]    w_rx_dout;
  logic [CW-1:0] w_tx_cnt;
  logic [CW-1:0] w_rx_cnt;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic          w_tx_pop;
  logic          w_rx_push;
  logic          w_drop_evt;
  logic          w_uf_evt;
  logic          r_tx_drop;
  logic          r_rx_uf;
  logic [31:0]   w_cpuin;
  logic          w_unused;

  assign w_cmd_push = bus.IOWrite && bus.CPUOut[CMD_PUSH];
  assign w_cmd_pop  = bus.IOWrite && bus.CPUOut[CMD_POP];
  assign w_cmd_clr  = bus.IOWrite && bus.CPUOut[CMD_CLR];
  assign w_unused   = ^bus.CPUOut[31:11];

  assign w_tx_pop   = !w_tx_empty && bus.tx_ready;
  assign w_rx_push  = bus.rx_valid && !w_rx_full;
  assign w_drop_evt = w_cmd_push && w_tx_full && !w_tx_pop;
  assign w_uf_evt   = w_cmd_pop && w_rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .CW(CW)) u_tx_fifo (
    .clk   (CLK),
    .rst   (Reset),
    .push  (w_cmd_push),
    .pop   (w_tx_pop),
    .din   (bus.CPUOut[7:0]),
    .dout  (w_tx_dout),
    .count (w_tx_cnt),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .CW(CW)) u_rx_fifo (
    .clk   (CLK),
    .rst   (Reset),
    .push  (w_rx_push),
    .pop   (w_cmd_pop),
    .din   (bus.rx_data),
    .dout  (w_rx_dout),
    .count (w_rx_cnt),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

  // A new error in the same write as CLR wins, so the flag loads the event itself.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_tx_drop <= 1'b0;
      r_rx_uf   <= 1'b0;
    end else begin
      if (w_cmd_clr || w_drop_evt) r_tx_drop <= w_drop_evt;
      if (w_cmd_clr || w_uf_evt)   r_rx_uf   <= w_uf_evt;
    end
  end

  always_comb begin
    w_cpuin            = '0;
    w_cpuin[7:0]       = w_rx_dout;
    w_cpuin[ST_RXNE]   = !w_rx_empty;
    w_cpuin[ST_TXF]    = w_tx_full;
    w_cpuin[ST_TXE]    = w_tx_empty;
    w_cpuin[ST_TXDROP] = r_tx_drop;
    w_cpuin[ST_RXUF]   = r_rx_uf;
    w_cpuin[ST_TXCNT_LSB +: ST_CNT_W] = ST_CNT_W'(w_tx_cnt);
    w_cpuin[ST_RXCNT_LSB +: ST_CNT_W] = ST_CNT_W'(w_rx_cnt);
  end

  assign bus.CPUIn    = w_cpuin;
  assign bus.tx_valid = !w_tx_empty;
  assign bus.tx_data  = w_tx_dout;
  assign bus.rx_ready = !w_rx_full;
endmodule

// File: tb/tb_io_bridge.sv
// Bench for io_bridge: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_io_bridge;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       m_drop;
  logic       m_uf;

  io_bridge_if bus();

  io_bridge #(.DEPTH(DEPTH), .CW(5)) u_dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_cpuin();
    logic [31:0] w;
    w = '0;
    w[7:0]   = (rxq.size() > 0) ? rxq[0] : 8'h00;
    w[8]     = rxq.size() > 0;
    w[9]     = txq.size() == DEPTH;
    w[10]    = txq.size() == 0;
    w[11]    = m_drop;
    w[12]    = m_uf;
    w[20:16] = 5'(txq.size());
    w[28:24] = 5'(rxq.size());
    return w;
  endfunction

  task automatic check_all();
    chk("cpuin", bus.CPUIn, model_cpuin());
    chk("tx_valid", 32'(bus.tx_valid), 32'(txq.size() > 0));
    chk("tx_data", 32'(bus.tx_data), (txq.size() > 0) ? 32'(txq[0]) : 32'h0);
    chk("rx_ready", 32'(bus.rx_ready), 32'(rxq.size() < DEPTH));
  endtask

  // One clock: drive inputs, advance the model on the same edge, check post-edge state.
  task automatic step(input logic r, input logic iow, input logic [31:0] cmd,
                      input logic txr, input logic rxv, input logic [7:0] rxd);
    logic tx_pop, psh, pop, clr, rx_push, drop_evt, uf_evt;
    @(negedge clk);
    rst          = r;
    bus.IOWrite  = iow;
    bus.CPUOut   = cmd;
    bus.tx_ready = txr;
    bus.rx_valid = rxv;
    bus.rx_data  = rxd;
    if (r) begin
      txq.delete();
      rxq.delete();
      m_drop = 1'b0;
      m_uf   = 1'b0;
    end else begin
      tx_pop   = txr && (txq.size() > 0);
      psh      = iow && cmd[8];
      pop      = iow && cmd[9];
      clr      = iow && cmd[10];
      rx_push  = rxv && (rxq.size() < DEPTH);
      drop_evt = psh && !((txq.size() < DEPTH) || tx_pop);
      uf_evt   = pop && (rxq.size() == 0);
      if (tx_pop) void'(txq.pop_front());
      if (psh && !drop_evt) txq.push_back(cmd[7:0]);
      if (pop && rxq.size() > 0) void'(rxq.pop_front());
      if (rx_push) rxq.push_back(rxd);
      if (clr) begin
        m_drop = 1'b0;
        m_uf   = 1'b0;
      end
      if (drop_evt) m_drop = 1'b1;
      if (uf_evt)   m_uf   = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input logic txr);
    step(1'b0, 1'b0, 32'h0, txr, 1'b0, 8'h00);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_drop  = 1'b0;
    m_uf    = 1'b0;
    rst = 1'b1;
    bus.IOWrite = 1'b0; bus.CPUOut = '0; bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = '0;

    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    chk("reset_cpuin", bus.CPUIn, 32'h0000_0400);
    chk("reset_txv", 32'(bus.tx_valid), 32'h0);
    chk("reset_rxr", 32'(bus.rx_ready), 32'h1);

    // Reset mid-operation, colliding with a push, an RX handshake and a TX handshake.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h100 | i, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 32'h1FF, 1'b1, 1'b1, 8'h77);
    chk("midrst_cpuin", bus.CPUIn, 32'h0000_0400);
    chk("midrst_txv", 32'(bus.tx_valid), 32'h0);
    chk("midrst_txd", 32'(bus.tx_data), 32'h0);
    chk("midrst_rxr", 32'(bus.rx_ready), 32'h1);

    // TX ordering
    step(1'b0, 1'b1, 32'h141, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 32'h142, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 32'h143, 1'b0, 1'b0, 8'h00);
    chk("txo_cnt3", 32'(bus.CPUIn[20:16]), 32'd3);
    chk("txo_d0", 32'(bus.tx_data), 32'h41);
    idle(1'b1);
    chk("txo_d1", 32'(bus.tx_data), 32'h42);
    idle(1'b1);
    chk("txo_d2", 32'(bus.tx_data), 32'h43);
    idle(1'b1);
    chk("txo_cnt0", 32'(bus.CPUIn[20:16]), 32'd0);
    chk("txo_empty", 32'(bus.CPUIn[10]), 32'h1);

    // TX overflow and sticky clear
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'h100 | i, 1'b0, 1'b0, 8'h00);
    chk("ovf_drop", 32'(bus.CPUIn[11]), 32'h1);
    chk("ovf_full", 32'(bus.CPUIn[9]), 32'h1);
    chk("ovf_cnt", 32'(bus.CPUIn[20:16]), 32'd8);
    step(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 8'h00);
    chk("clr_drop", 32'(bus.CPUIn[11]), 32'h0);

    // Full FIFO with a drain in the same cycle as a push
    step(1'b0, 1'b1, 32'h199, 1'b1, 1'b0, 8'h00);
    chk("fulldrain_cnt", 32'(bus.CPUIn[20:16]), 32'd8);
    chk("fulldrain_drop", 32'(bus.CPUIn[11]), 32'h0);
    for (int i = 0; i < 7; i++) idle(1'b1);
    chk("fulldrain_last", 32'(bus.tx_data), 32'h99);
    idle(1'b1);
    chk("fulldrain_empty", 32'(bus.tx_valid), 32'h0);

    // RX path and underflow
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8'hA5);
    chk("rx_first", 32'(bus.CPUIn[8:0]), 32'h1A5);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 8'h00);
    chk("rx_pop1", 32'(bus.CPUIn[8:0]), 32'h15A);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 8'h00);
    chk("rx_pop2", 32'(bus.CPUIn[8:0]), 32'h0);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 8'h00);
    chk("rx_uf", 32'(bus.CPUIn[12]), 32'h1);
    // CLR together with a fresh underflow leaves the flag set
    step(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 8'h00);
    chk("rx_uf_clr_evt", 32'(bus.CPUIn[12]), 32'h1);
    step(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 8'h00);

    // RX full, then a POP alongside an offered byte
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8'(8'h10 + i));
    chk("rxfull_rdy", 32'(bus.rx_ready), 32'h0);
    chk("rxfull_cnt", 32'(bus.CPUIn[28:24]), 32'd8);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 8'hEE);
    chk("rxfull_pop_cnt", 32'(bus.CPUIn[28:24]), 32'd7);
    chk("rxfull_pop_rdy", 32'(bus.rx_ready), 32'h1);
    chk("rxfull_pop_head", 32'(bus.CPUIn[7:0]), 32'h11);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] c;
      c = $urandom;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1), c,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
